// File: rtl/s3_pc_stk.sv
// S3 sequencer program counter: conditional jump, call/return through a small
// return-address stack, a decrement-and-branch loop counter, and a pipeline stall.
module s3_pc_stk #(
   parameter int AW = 8,
   parameter int CW = 4,
   parameter int SD = 4,
   parameter int LW = 8,
   localparam int SPW = $clog2(SD + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          op_jmp,
   input  logic          op_call,
   input  logic          op_ret,
   input  logic          op_loop,
   input  logic          op_djnz,
   input  logic [AW-1:0] op_tgt,
   input  logic [LW-1:0] op_imm,
   input  logic          op_cond_inv,
   input  logic [CW-1:0] op_cond_mask,
   input  logic [CW-1:0] op_cond_val,
   input  logic [CW-1:0] a_reg,
   input  logic          err_clr,
   output logic [AW-1:0] pc,
   output logic [LW-1:0] lp_cnt,
   output logic [SPW-1:0] sp,
   output logic          stk_ovf,
   output logic          stk_unf
);

   localparam int IW = (SD > 1) ? $clog2(SD) : 1;

   logic [AW-1:0]  stk [SD];
   logic           cond;
   logic [AW-1:0]  pc_inc;
   logic [LW-1:0]  lp_dec;
   logic [SPW-1:0] sp_dec;
   logic [IW-1:0]  push_idx;
   logic [IW-1:0]  top_idx;
   logic [AW-1:0]  pc_nxt;
   logic [SPW-1:0] sp_nxt;
   logic [LW-1:0]  lp_nxt;
   logic           push;
   logic           ovf_set;
   logic           unf_set;

   assign cond     = (((a_reg ^ op_cond_val) & op_cond_mask) == '0) ^ op_cond_inv;
   assign pc_inc   = pc + AW'(1);
   assign lp_dec   = lp_cnt - LW'(1);
   assign sp_dec   = sp - SPW'(1);
   assign push_idx = sp[IW-1:0];
   assign top_idx  = sp_dec[IW-1:0];

   // Strobes are decoded with strict priority ret > call > djnz > jmp > loop;
   // a stalled cycle leaves every next-state value equal to the current one.
   always_comb begin
      pc_nxt  = pc_inc;
      sp_nxt  = sp;
      lp_nxt  = lp_cnt;
      push    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (stall) begin
         pc_nxt = pc;
      end else if (op_ret) begin
         if (cond) begin
            if (sp != '0) begin
               pc_nxt = stk[top_idx];
               sp_nxt = sp_dec;
            end else begin
               unf_set = 1'b1;
            end
         end
      end else if (op_call) begin
         if (cond) begin
            if (sp < SPW'(SD)) begin
               push   = 1'b1;
               sp_nxt = sp + SPW'(1);
               pc_nxt = op_tgt;
            end else begin
               ovf_set = 1'b1;
            end
         end
      end else if (op_djnz) begin
         if (lp_cnt != '0) begin
            lp_nxt = lp_dec;
            if (lp_dec != '0) pc_nxt = op_tgt;
         end
      end else if (op_jmp) begin
         if (cond) pc_nxt = op_tgt;
      end else if (op_loop) begin
         lp_nxt = op_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc      <= '0;
         sp      <= '0;
         lp_cnt  <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else begin
         pc      <= pc_nxt;
         sp      <= sp_nxt;
         lp_cnt  <= lp_nxt;
         stk_ovf <= ovf_set | (stk_ovf & ~err_clr);
         stk_unf <= unf_set | (stk_unf & ~err_clr);
      end
   end

   // Entries are never cleared; only sp says which ones are live.
   always_ff @(posedge clk) begin
      if (rst && push) stk[push_idx] <= pc_inc;
   end

endmodule

// File: tb/tb_s3_pc_stk.sv
// Directed bench for s3_pc_stk: free run, conditional jump, nested calls,
// loop counter, op priority, stall and reset while busy.
module tb_s3_pc_stk;

   localparam int AW = 8;
   localparam int CW = 4;
   localparam int SD = 4;
   localparam int LW = 8;
   localparam int SPW = $clog2(SD + 1);

   logic          clk;
   logic          rst;
   logic          stall;
   logic          op_jmp;
   logic          op_call;
   logic          op_ret;
   logic          op_loop;
   logic          op_djnz;
   logic [AW-1:0] op_tgt;
   logic [LW-1:0] op_imm;
   logic          op_cond_inv;
   logic [CW-1:0] op_cond_mask;
   logic [CW-1:0] op_cond_val;
   logic [CW-1:0] a_reg;
   logic          err_clr;
   logic [AW-1:0] pc;
   logic [LW-1:0] lp_cnt;
   logic [SPW-1:0] sp;
   logic          stk_ovf;
   logic          stk_unf;

   int errors = 0;
   int checks = 0;
   logic [AW-1:0] exp_q[$];

   s3_pc_stk #(.AW(AW), .CW(CW), .SD(SD), .LW(LW)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .op_jmp(op_jmp), .op_call(op_call), .op_ret(op_ret),
      .op_loop(op_loop), .op_djnz(op_djnz),
      .op_tgt(op_tgt), .op_imm(op_imm),
      .op_cond_inv(op_cond_inv), .op_cond_mask(op_cond_mask),
      .op_cond_val(op_cond_val), .a_reg(a_reg), .err_clr(err_clr),
      .pc(pc), .lp_cnt(lp_cnt), .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One edge, then sample #1 later and return all op inputs to idle
   // (condition fields idle to mask 0, i.e. always true).
   task automatic tick();
      @(posedge clk);
      #1;
      stall        = 1'b0;
      op_jmp       = 1'b0;
      op_call      = 1'b0;
      op_ret       = 1'b0;
      op_loop      = 1'b0;
      op_djnz      = 1'b0;
      op_tgt       = '0;
      op_imm       = '0;
      op_cond_inv  = 1'b0;
      op_cond_mask = '0;
      op_cond_val  = '0;
      a_reg        = '0;
      err_clr      = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int e_pc, input int e_sp,
                          input int e_lp, input int e_ovf, input int e_unf);
      chk({tag, ".pc"}, 32'(pc), e_pc);
      chk({tag, ".sp"}, 32'(sp), e_sp);
      chk({tag, ".lp"}, 32'(lp_cnt), e_lp);
      chk({tag, ".ovf"}, 32'(stk_ovf), e_ovf);
      chk({tag, ".unf"}, 32'(stk_unf), e_unf);
   endtask

   task automatic do_jmp(input int tgt);
      op_jmp = 1'b1; op_tgt = AW'(tgt); tick();
   endtask

   task automatic do_call(input int tgt);
      op_call = 1'b1; op_tgt = AW'(tgt); tick();
   endtask

   task automatic do_ret();
      op_ret = 1'b1; tick();
   endtask

   initial begin
      logic [AW-1:0] e;
      rst = 1'b0;
      tick();
      for (int i = 0; i < 9; i++) tick();
      chk_all("reset", 0, 0, 0, 0, 0);

      // free run through the wrap point
      rst = 1'b1;
      e = '0;
      for (int i = 0; i < 260; i++) begin
         e = e + AW'(1);
         exp_q.push_back(e);
      end
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         chk("free.pc", 32'(pc), 32'(e));
      end
      chk("free.sp", 32'(sp), 0);
      chk("free.lp", 32'(lp_cnt), 0);

      // conditional jump: (0 ^ D) & F != 0 -> cond = inv
      op_cond_mask = 4'hF; op_cond_val = 4'hD; op_cond_inv = 1'b1;
      do_jmp(8'hA5);
      chk("jmp_inv1", 32'(pc), 32'hA5);
      op_cond_mask = 4'hF; op_cond_val = 4'hD; op_cond_inv = 1'b0;
      do_jmp(8'h33);
      chk("jmp_inv0", 32'(pc), 32'hA6);
      op_cond_mask = 4'h3; op_cond_val = 4'hD; a_reg = 4'h1;
      do_jmp(8'h80);
      chk("jmp_partial_mask", 32'(pc), 32'h80);
      do_jmp(10);
      chk("jmp_mask0", 32'(pc), 10);

      // nested calls up to full, then overflow
      do_call(20); chk_all("call1", 20, 1, 0, 0, 0);
      do_call(30); chk_all("call2", 30, 2, 0, 0, 0);
      do_call(40); chk_all("call3", 40, 3, 0, 0, 0);
      do_call(50); chk_all("call4", 50, 4, 0, 0, 0);
      do_call(99); chk_all("call_ovf", 51, 4, 0, 1, 0);
      do_ret(); chk_all("ret1", 41, 3, 0, 1, 0);
      do_ret(); chk_all("ret2", 31, 2, 0, 1, 0);
      do_ret(); chk_all("ret3", 21, 1, 0, 1, 0);
      do_ret(); chk_all("ret4", 11, 0, 0, 1, 0);
      do_ret(); chk_all("ret_unf", 12, 0, 0, 1, 1);
      op_cond_mask = 4'hF; op_cond_val = 4'hD;
      do_call(77); chk_all("call_false", 13, 0, 0, 1, 1);
      // underflow coinciding with clear: set wins for unf, ovf clears
      op_ret = 1'b1; err_clr = 1'b1; tick();
      chk_all("clr_vs_set", 14, 0, 0, 0, 1);
      err_clr = 1'b1; tick();
      chk_all("err_clr", 15, 0, 0, 0, 0);

      // loop: body 6..8 three times
      do_jmp(5);
      chk("loop.jmp", 32'(pc), 5);
      op_loop = 1'b1; op_imm = 8'd3; tick();
      chk_all("loop.load", 6, 0, 3, 0, 0);
      for (int it = 0; it < 3; it++) begin
         tick(); tick();
         chk("loop.body_pc", 32'(pc), 8);
         op_djnz = 1'b1; op_tgt = 8'd6; tick();
         chk("loop.djnz_pc", 32'(pc), (it < 2) ? 6 : 9);
         chk("loop.djnz_lp", 32'(lp_cnt), 2 - it);
      end
      op_djnz = 1'b1; op_tgt = 8'd6; tick();
      chk_all("djnz_zero", 10, 0, 0, 0, 0);

      // priority
      op_jmp = 1'b1; op_tgt = 8'd40; op_loop = 1'b1; op_imm = 8'd9; tick();
      chk_all("jmp_over_loop", 40, 0, 0, 0, 0);
      do_call(60); chk_all("prio.call", 60, 1, 0, 0, 0);
      op_ret = 1'b1; op_jmp = 1'b1; op_tgt = 8'd100; tick();
      chk_all("ret_over_jmp", 41, 0, 0, 0, 0);

      // stall during a call
      op_loop = 1'b1; op_imm = 8'd7; tick();
      chk_all("stall.setup", 42, 0, 7, 0, 0);
      for (int s = 0; s < 5; s++) begin
         stall = 1'b1; op_call = 1'b1; op_tgt = 8'd70; tick();
         chk_all("stall.hold", 42, 0, 7, 0, 0);
      end
      do_call(70); chk_all("stall.release", 70, 1, 7, 0, 0);

      // build sp=3, lp=7, ovf=1, then reset under stall
      do_call(80);
      do_call(90);
      do_call(100); chk_all("rst.fill", 100, 4, 7, 0, 0);
      do_call(110); chk_all("rst.ovf", 101, 4, 7, 1, 0);
      do_ret(); chk_all("rst.setup", 91, 3, 7, 1, 0);
      rst = 1'b0; stall = 1'b1; op_call = 1'b1; op_tgt = 8'd5; tick();
      chk_all("rst.mid", 0, 0, 0, 0, 0);
      rst = 1'b1; tick();
      chk_all("rst.after", 1, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
